// File: rtl/multi_debouncer_pkg.sv
// Shared constants, channel state encoding and width helpers for multi_debouncer.
// Default cycle counts assume the 100 MHz board clock.
package multi_debouncer_pkg;

  localparam int unsigned CLK_HZ              = 100_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 50_000;      // 0.5 ms
  localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;  // 250 ms
  localparam int unsigned DEF_REPEAT_CYCLES   = 5_000_000;   // 50 ms

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } chan_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Width able to hold 0..terminal; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal < 1) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/multi_debouncer_channel.sv
// One switch channel: 2-FF synchroniser, stability counter, registered edge
// pulses and an optional hold-to-repeat generator.
module debounce_channel
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic repeat_pulse
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (s2 != clean) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      cnt        <= '0;
      clean      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      s1         <= noisy;
      s2         <= s1;
      rise_pulse <= accept & s2;
      fall_pulse <= accept & ~s2;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (accept) begin
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  if (REPEAT_EN) begin : g_repeat
    localparam int unsigned HCNT_W = cnt_width(max_u(HOLD_CYCLES, REPEAT_CYCLES));

    chan_state_t       state;
    logic [HCNT_W-1:0] hcnt;
    logic              rep;

    always_ff @(posedge clk) begin
      if (reset) begin
        state <= IDLE;
        hcnt  <= '0;
        rep   <= 1'b0;
      end else begin
        rep <= 1'b0;
        // An accepted release is checked first so it suppresses a coincident repeat.
        if (accept && !s2) begin
          state <= IDLE;
          hcnt  <= '0;
        end else begin
          unique case (state)
            IDLE: begin
              if (accept && s2) begin
                state <= HELD;
                hcnt  <= '0;
              end
            end
            HELD: begin
              if (hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
                rep   <= 1'b1;
                hcnt  <= '0;
                state <= REPEAT;
              end else begin
                hcnt <= hcnt + HCNT_W'(1);
              end
            end
            REPEAT: begin
              if (hcnt == HCNT_W'(REPEAT_CYCLES - 1)) begin
                rep  <= 1'b1;
                hcnt <= '0;
              end else begin
                hcnt <= hcnt + HCNT_W'(1);
              end
            end
            default: begin
              state <= IDLE;
              hcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign repeat_pulse = rep;
  end else begin : g_no_repeat
    assign repeat_pulse = 1'b0;
  end

endmodule

// File: rtl/multi_debouncer.sv
// N independent debounced switch channels with edge and auto-repeat event pulses
// for the game FSM.
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned N               = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] noisy_in,
  output logic [N-1:0] clean_out,
  output logic [N-1:0] rise_pulse,
  output logic [N-1:0] fall_pulse,
  output logic [N-1:0] repeat_pulse,
  output logic [N-1:0] press_event
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .noisy        (noisy_in[i]),
      .clean        (clean_out[i]),
      .rise_pulse   (rise_pulse[i]),
      .fall_pulse   (fall_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end

  assign press_event = rise_pulse | repeat_pulse;

endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer: expected outputs per cycle are derived
// from press/release timing and compared against a repeat-enabled and a repeat-disabled DUT.
module tb_multi_debouncer;

  localparam int unsigned NCH = 2;
  localparam int D   = 4;
  localparam int H   = 10;
  localparam int RP  = 3;
  localparam int MAXLEN = 64;
  localparam int NEVER  = 1000;

  typedef struct packed {
    logic [NCH-1:0] clean;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] rep;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] noisy_in;

  logic [NCH-1:0] clean_a, rise_a, fall_a, rep_a, press_a;
  logic [NCH-1:0] clean_b, rise_b, fall_b, rep_b, press_b;

  logic [NCH-1:0] stim_a [MAXLEN];
  logic           rst_a  [MAXLEN];
  logic [NCH-1:0] e_clean[MAXLEN];
  logic [NCH-1:0] e_rise [MAXLEN];
  logic [NCH-1:0] e_fall [MAXLEN];
  logic [NCH-1:0] e_rep  [MAXLEN];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  multi_debouncer #(
    .N               (NCH),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (RP),
    .REPEAT_EN       (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .noisy_in     (noisy_in),
    .clean_out    (clean_a),
    .rise_pulse   (rise_a),
    .fall_pulse   (fall_a),
    .repeat_pulse (rep_a),
    .press_event  (press_a)
  );

  multi_debouncer #(
    .N               (NCH),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (RP),
    .REPEAT_EN       (1'b0)
  ) dut_norep (
    .clk          (clk),
    .reset        (reset),
    .noisy_in     (noisy_in),
    .clean_out    (clean_b),
    .rise_pulse   (rise_b),
    .fall_pulse   (fall_b),
    .repeat_pulse (rep_b),
    .press_event  (press_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_plan();
    for (int k = 0; k < MAXLEN; k++) begin
      stim_a[k]  = '0;
      rst_a[k]   = 1'b0;
      e_clean[k] = '0;
      e_rise[k]  = '0;
      e_fall[k]  = '0;
      e_rep[k]   = '0;
    end
  endtask

  // Input on channel ch is high for steps [p,q); expectations written for steps [lo,hi).
  task automatic press(input int ch, input int p, input int q, input int lo, input int hi);
    int r, f;
    r = p + D + 1;
    f = q + D + 1;
    for (int k = lo; k < hi; k++) begin
      if (k >= p && k < q) stim_a[k][ch] = 1'b1;
      if (k >= r && k < f) e_clean[k][ch] = 1'b1;
      if (k == r)          e_rise[k][ch]  = 1'b1;
      if (k == f)          e_fall[k][ch]  = 1'b1;
      if (k >= r + H && k < f && ((k - r - H) % RP) == 0) e_rep[k][ch] = 1'b1;
    end
  endtask

  task automatic run(input string name, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.clean = e_clean[k];
      e.rise  = e_rise[k];
      e.fall  = e_fall[k];
      e.rep   = e_rep[k];
      sb.push_back(e);
    end
    for (int k = 0; k < len; k++) begin
      noisy_in = stim_a[k];
      reset    = rst_a[k];
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        check_eq($sformatf("%s[%0d].sb_empty", name, k), 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq($sformatf("%s[%0d].clean", name, k), 32'(clean_a), 32'(e.clean));
        check_eq($sformatf("%s[%0d].rise",  name, k), 32'(rise_a),  32'(e.rise));
        check_eq($sformatf("%s[%0d].fall",  name, k), 32'(fall_a),  32'(e.fall));
        check_eq($sformatf("%s[%0d].rep",   name, k), 32'(rep_a),   32'(e.rep));
        check_eq($sformatf("%s[%0d].press", name, k), 32'(press_a), 32'(e.rise | e.rep));
        check_eq($sformatf("%s[%0d].nr_clean", name, k), 32'(clean_b), 32'(e.clean));
        check_eq($sformatf("%s[%0d].nr_rise",  name, k), 32'(rise_b),  32'(e.rise));
        check_eq($sformatf("%s[%0d].nr_fall",  name, k), 32'(fall_b),  32'(e.fall));
        check_eq($sformatf("%s[%0d].nr_rep",   name, k), 32'(rep_b),   32'd0);
        check_eq($sformatf("%s[%0d].nr_press", name, k), 32'(press_b), 32'(e.rise));
      end
    end
  endtask

  task automatic do_reset(input string name);
    reset    = 1'b1;
    noisy_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq({name, ".rst_clean"}, 32'({clean_b, clean_a}), 32'd0);
    check_eq({name, ".rst_rise"},  32'({rise_b, rise_a}),   32'd0);
    check_eq({name, ".rst_fall"},  32'({fall_b, fall_a}),   32'd0);
    check_eq({name, ".rst_rep"},   32'({rep_b, rep_a}),     32'd0);
    check_eq({name, ".rst_press"}, 32'({press_b, press_a}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    noisy_in = '0;

    // Clean press on ch0 only; ch1 stays idle.
    do_reset("init");
    clear_plan();
    press(0, 0, NEVER, 0, 12);
    run("press", 12);

    // Long hold with repeats on ch0, overlapping independent press on ch1.
    do_reset("pre_hold");
    clear_plan();
    press(0, 0, 35, 0, 45);
    press(1, 2, 20, 0, 45);
    run("hold", 45);

    // Bounce: 1,0,1,0 then held high from step 4.
    do_reset("pre_bounce");
    clear_plan();
    stim_a[0][0] = 1'b1;
    stim_a[2][0] = 1'b1;
    press(0, 4, NEVER, 0, 20);
    run("bounce", 20);

    // Glitches shorter than the debounce window.
    do_reset("pre_glitch");
    clear_plan();
    for (int k = 0; k < 3; k++) stim_a[k][0] = 1'b1;
    stim_a[5][1] = 1'b1;
    run("glitch", 15);

    // Accepted release lands on R+13, where a repeat would otherwise fire.
    do_reset("pre_bound");
    clear_plan();
    press(0, 0, 13, 0, 25);
    press(1, 0, 13, 0, 25);
    run("bound", 25);

    // Reset while ch1 count is at 3 and ch0 is already clean-high; inputs stay high.
    do_reset("pre_midrst");
    clear_plan();
    press(0, 0, NEVER, 0, 9);
    press(1, 4, NEVER, 0, 9);
    stim_a[9] = '1;
    rst_a[9]  = 1'b1;
    press(0, 10, NEVER, 10, 24);
    press(1, 10, NEVER, 10, 24);
    run("midrst", 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
